// File: rtl/jt49_dcfilt_sat.sv
// ---------------------------------------------------------------------------
// jt49_dcfilt_sat
// Purpose : scales the signed DC-free difference by 2^(4+gain) and clamps the
//           result to the signed 16-bit range (no wrap-around).
// Ports   :
//   i_diff  in  11  signed difference, range -1023..+1023
//   i_gain  in   2  left-shift select, shift = 4 + i_gain
//   o_dout  out 16  saturated signed result (combinational)
// ---------------------------------------------------------------------------
module jt49_dcfilt_sat (
    input  logic [10:0] i_diff,
    input  logic [1:0]  i_gain,
    output logic [15:0] o_dout
);

    // 1023 << 7 needs 18 signed bits, so scaling is done at that width.
    localparam logic signed [17:0] SAT_MAX = 18'sd32767;
    localparam logic signed [17:0] SAT_MIN = -18'sd32768;

    logic        [2:0]  w_shamt;
    logic signed [17:0] w_ext;
    logic signed [17:0] w_scaled;

    // Sign-extend, scale by the selected power of two, then clamp.
    always_comb begin
        w_shamt  = 3'd4 + {1'b0, i_gain};
        w_ext    = $signed({{7{i_diff[10]}}, i_diff});
        w_scaled = w_ext <<< w_shamt;
        if (w_scaled > SAT_MAX) begin
            o_dout = 16'h7FFF;
        end else if (w_scaled < SAT_MIN) begin
            o_dout = 16'h8000;
        end else begin
            o_dout = w_scaled[15:0];
        end
    end

endmodule

// File: rtl/jt49_dcfilt.sv
// ---------------------------------------------------------------------------
// jt49_dcfilt
// Purpose : removes the DC offset from the unsigned PSG mix with a leaky
//           integrator, then scales and saturates the result to 16 bits.
// Ports   :
//   clk     in   1  rising-edge system clock
//   rst_n   in   1  asynchronous active-low reset
//   sample  in   1  one-clk strobe qualifying din
//   din     in  10  unsigned PSG sound
//   gain    in   2  output shift select (4 + gain), taken on the output clk
//   mute    in   1  zero the output sample on the output clk
//   dout    out 16  signed, DC-free, scaled audio (held between updates)
//   valid   out  1  one-clk pulse, one clk after each accepted sample
// ---------------------------------------------------------------------------
module jt49_dcfilt #(
    parameter int SHIFT = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample,
    input  logic [9:0]  din,
    input  logic [1:0]  gain,
    input  logic        mute,
    output logic [15:0] dout,
    output logic        valid
);

    localparam int AW = 10 + SHIFT;

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_load_warm;
    logic            w_load_run;

    logic [AW-1:0]   r_acc;
    logic [9:0]      r_x;
    logic [9:0]      r_dcs;
    logic            r_pend;
    logic [15:0]     r_dout;
    logic            r_valid;

    logic [9:0]      w_dc;
    logic [AW-1:0]   w_acc_next;
    logic [10:0]     w_diff;
    logic [15:0]     w_scaled;

    // Integer part of the accumulator is the running DC estimate.
    assign w_dc       = r_acc[AW-1:SHIFT];
    // acc converges to dc<<SHIFT, so acc + din - dc never leaves [0, 1023<<SHIFT].
    assign w_acc_next = r_acc + {{SHIFT{1'b0}}, din} - {{SHIFT{1'b0}}, w_dc};
    // Zero-extended operands make the 11-bit result a correct signed difference.
    assign w_diff     = {1'b0, r_x} - {1'b0, r_dcs};

    jt49_dcfilt_sat u_sat (
        .i_diff (w_diff),
        .i_gain (gain),
        .o_dout (w_scaled)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WARM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic: the first accepted sample ends warm-up.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WARM: begin
                if (sample) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_WARM;
                end
            end
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_WARM;
        endcase
    end

    // FSM output logic: which datapath load happens on an accepted sample.
    always_comb begin
        w_load_warm = 1'b0;
        w_load_run  = 1'b0;
        case (r_state)
            ST_WARM: w_load_warm = sample;
            ST_RUN:  w_load_run  = sample;
            default: begin
                w_load_warm = 1'b0;
                w_load_run  = 1'b0;
            end
        endcase
    end

    // Integrator datapath; warm-up preloads acc so the first output is zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= {AW{1'b0}};
            r_x   <= 10'd0;
            r_dcs <= 10'd0;
        end else if (w_load_warm) begin
            r_acc <= {din, {SHIFT{1'b0}}};
            r_x   <= din;
            r_dcs <= din;
        end else if (w_load_run) begin
            r_acc <= w_acc_next;
            r_x   <= din;
            r_dcs <= w_dc;
        end else begin
            r_acc <= r_acc;
            r_x   <= r_x;
            r_dcs <= r_dcs;
        end
    end

    // Output stage: one result per accepted sample, one clk later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= 1'b0;
            r_dout  <= 16'd0;
            r_valid <= 1'b0;
        end else begin
            r_pend  <= sample;
            r_valid <= r_pend;
            if (r_pend) begin
                r_dout <= mute ? 16'd0 : w_scaled;
            end else begin
                r_dout <= r_dout;
            end
        end
    end

    assign dout  = r_dout;
    assign valid = r_valid;

endmodule

// File: doc/jt49_dcfilt.md
JT49_DCFILT -- requirements
Module: jt49_dcfilt

Interface
REQ-001 SHALL have parameter SHIFT, default 6, meaning leaky-integrator time-constant exponent (legal 4..10).
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port sample  input  1  one-clk strobe marking a valid din (driven from the PSG sample output).
REQ-005 SHALL have port din  input  10  unsigned combined PSG sound.
REQ-006 SHALL have port gain  input  2  output left-shift select: shift = 4 + gain.
REQ-007 SHALL have port mute  input  1  forces output samples to zero while high.
REQ-008 SHALL have port dout  output  16  signed, DC-free, scaled audio.
REQ-009 SHALL have port valid  output  1  one-clk pulse when dout updates.

Function
REQ-010 SHALL hold an unsigned accumulator acc of width 10+SHIFT; DC estimate dc = acc[9+SHIFT:SHIFT].
REQ-011 SHALL implement a two-state FSM: WARM (after reset) and RUN.
REQ-012 In WARM, on a clk with sample=1: acc <= {din, SHIFT zeros}, x <= din, dcs <= din, go to RUN.
REQ-013 In RUN, on a clk with sample=1: x <= din, dcs <= dc (pre-update value), acc <= acc + din - dc (full width, no wrap; the result stays in range by construction).
REQ-014 SHALL compute diff = x - dcs as 11-bit signed value, range -1023..+1023.
REQ-015 On the clk after each accepted sample: dout <= sat16(diff * 2^(4+gain)), valid <= 1; latency from sample to valid is exactly 1 clk.
REQ-016 sat16 SHALL clamp to +32767 / -32768; no wrap-around permitted.
REQ-017 valid SHALL be 0 on every clk not following an accepted sample; dout holds its value between updates.
REQ-018 gain SHALL be sampled on the output clk (the valid cycle), not on the sample clk.
REQ-019 If mute=1 on the output clk, dout <= 0 and valid still pulses; the acc update is not affected by mute.
REQ-020 Back-to-back sample strobes (consecutive clks) SHALL each be accepted; valid then stays high for consecutive clks, with one output per input.
REQ-021 sample=0 SHALL leave acc, x, dcs and state unchanged.

Reset
REQ-022 While rst_n=0: state=WARM, acc=0, x=0, dcs=0, dout=0, valid=0.
REQ-023 Reset asserted mid-operation SHALL clear everything immediately; no valid pulse for a sample pending at reset.
REQ-024 The first output after reset SHALL be 0 (no start-up thump).

Structure
REQ-025 No shared package; SHIFT is a module parameter and all widths are derived from it locally.
REQ-026 One sub-module jt49_dcfilt_sat (signed 11-bit in, 2-bit shift select, saturated 16-bit out, combinational) is natural; everything else is in jt49_dcfilt.
REQ-027 Total RTL SHALL stay within 120-400 lines.

Verification
REQ-028 Reset, then sample with din=512 -> next clk valid=1, dout=0; acc=512<<6.
REQ-029 SHIFT=6, gain=1, din held at 512 after warm-up, then step to 612 -> first output dout=+3200 (100<<5), decaying toward 0 over ~64·ln samples.
REQ-030 Warm-up at din=0, then din=1023, gain=3 -> 1023<<7 overflows, so dout=+32767; with warm-up at 1023 and din=0 -> dout=-32768.
REQ-031 Samples on 3 consecutive clks -> valid high for exactly 3 consecutive clks, one clk delayed, each dout matching the reference model.
REQ-032 mute=1 during a step -> dout=0 with valid pulse; release mute -> outputs match an unmuted model run (acc unaffected).
REQ-033 rst_n pulsed low on the sample clk -> no valid pulse; the next sample re-enters WARM and its output is 0.
